ysyx_22050710_data_sram: RTL and testbench

YSYX_22050710_DATA_SRAM -- requirements
Module: ysyx_22050710_data_sram

---
 rtl/ysyx_22050710_data_sram_pkg.sv | 7 +
 rtl/ysyx_22050710_wmask_merge.sv | 16 +
 rtl/ysyx_22050710_data_sram.sv | 63 ++++++
 tb/tb_ysyx_22050710_data_sram.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_data_sram_pkg.sv
// ysyx_22050710_data_sram_pkg: shared core widths and the data SRAM base address
package ysyx_22050710_data_sram_pkg;
    localparam int          DEF_ADDR_WD   = 32;
    localparam int          DEF_DATA_WD   = 64;
    localparam int          DEF_WMASK_WD  = 8;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
endpackage

// File: rtl/ysyx_22050710_wmask_merge.sv
// ysyx_22050710_wmask_merge: replace the bytes of a word selected by a byte mask
module ysyx_22050710_wmask_merge
    import ysyx_22050710_data_sram_pkg::*;
#(
    parameter int DATA_WD  = DEF_DATA_WD,
    parameter int WMASK_WD = DATA_WD / 8
) (
    input  logic [DATA_WD-1:0]  old_word,
    input  logic [DATA_WD-1:0]  wdata,
    input  logic [WMASK_WD-1:0] wmask,
    output logic [DATA_WD-1:0]  new_word
);
    for (genvar g = 0; g < WMASK_WD; g++) begin : g_lane
        assign new_word[8*g +: 8] = wmask[g] ? wdata[8*g +: 8] : old_word[8*g +: 8];
    end
endmodule

// File: rtl/ysyx_22050710_data_sram.sv
// ysyx_22050710_data_sram: byte-masked data SRAM with 1-cycle reads, range check and access counters
module ysyx_22050710_data_sram
    import ysyx_22050710_data_sram_pkg::*;
#(
    parameter int                      SRAM_ADDR_WD  = DEF_ADDR_WD,
    parameter int                      SRAM_DATA_WD  = DEF_DATA_WD,
    parameter int                      SRAM_WMASK_WD = DEF_WMASK_WD,
    parameter int                      DEPTH         = 4096,
    parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR     = SRAM_ADDR_WD'(DEF_BASE_ADDR)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [SRAM_ADDR_WD-1:0]  i_data_sram_addr,
    input  logic                     i_data_sram_ren,
    input  logic                     i_data_sram_wen,
    input  logic [SRAM_WMASK_WD-1:0] i_data_sram_wmask,
    input  logic [SRAM_DATA_WD-1:0]  i_data_sram_wdata,
    output logic [SRAM_DATA_WD-1:0]  o_data_sram_rdata,
    output logic                     o_data_sram_rvalid,
    output logic                     o_data_sram_err,
    output logic [31:0]              o_rd_cnt,
    output logic [31:0]              o_wr_cnt
);
    localparam int OFF_WD = $clog2(SRAM_DATA_WD / 8);
    localparam int IDX_WD = $clog2(DEPTH);
    logic [SRAM_DATA_WD-1:0] mem [DEPTH];
    logic [SRAM_ADDR_WD-1:0] offset;
    logic [IDX_WD-1:0]       idx;
    logic [SRAM_DATA_WD-1:0] merged;
    logic                    in_range, rd, wr, oor;
    assign offset   = i_data_sram_addr - BASE_ADDR;
    assign idx      = IDX_WD'(offset >> OFF_WD);
    assign in_range = (i_data_sram_addr >= BASE_ADDR) && ((offset >> (OFF_WD + IDX_WD)) == '0);
    assign rd       = i_data_sram_ren & in_range;
    assign wr       = i_data_sram_wen & in_range;
    assign oor      = (i_data_sram_ren | i_data_sram_wen) & ~in_range;
    ysyx_22050710_wmask_merge #(
        .DATA_WD  (SRAM_DATA_WD),
        .WMASK_WD (SRAM_WMASK_WD)
    ) u_merge (
        .old_word (mem[idx]),
        .wdata    (i_data_sram_wdata),
        .wmask    (i_data_sram_wmask),
        .new_word (merged)
    );
    // memory contents survive reset; reads sample the pre-write word (read-before-write)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_sram_rdata  <= '0;
            o_data_sram_rvalid <= 1'b0;
            o_data_sram_err    <= 1'b0;
            o_rd_cnt           <= '0;
            o_wr_cnt           <= '0;
        end else begin
            if (wr) mem[idx] <= merged;
            if (i_data_sram_ren) o_data_sram_rdata <= in_range ? mem[idx] : '0;
            o_data_sram_rvalid <= i_data_sram_ren;
            o_data_sram_err    <= oor;
            o_rd_cnt           <= o_rd_cnt + 32'(rd);
            o_wr_cnt           <= o_wr_cnt + 32'(wr);
        end
    end
endmodule

// File: tb/tb_ysyx_22050710_data_sram.sv
// tb_ysyx_22050710_data_sram: directed and randomized checks of the data SRAM against a behavioural model
module tb_ysyx_22050710_data_sram;
    localparam longint unsigned BASE = 64'h8000_0000;
    localparam longint unsigned SPAN = 4096 * 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [7:0]  wmask = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    logic        rvalid, err;
    logic [31:0] rd_cnt, wr_cnt;
    int checks = 0, errors = 0;
    logic [63:0] mm [int unsigned];
    logic [63:0] exp_rdata = '0;
    logic        exp_rvalid = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rd = '0, exp_wr = '0;

    always #5 clk = ~clk;

    ysyx_22050710_data_sram dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_data_sram_addr   (addr),
        .i_data_sram_ren    (ren),
        .i_data_sram_wen    (wen),
        .i_data_sram_wmask  (wmask),
        .i_data_sram_wdata  (wdata),
        .o_data_sram_rdata  (rdata),
        .o_data_sram_rvalid (rvalid),
        .o_data_sram_err    (err),
        .o_rd_cnt           (rd_cnt),
        .o_wr_cnt           (wr_cnt)
    );

    task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
        longint unsigned la = 64'(a);
        bit inr = (la >= BASE) && (la < BASE + SPAN);
        int unsigned i = int'((la - BASE) / 8);
        logic [63:0] word;
        exp_rvalid = r;
        exp_err = (r || w) && !inr;
        if (r) exp_rdata = inr ? (mm.exists(i) ? mm[i] : 64'h0) : 64'h0;
        if (r && inr) exp_rd = exp_rd + 1;
        if (w && inr) begin
            word = mm.exists(i) ? mm[i] : 64'h0;
            for (int b = 0; b < 8; b++) if (m[b]) word[8*b +: 8] = d[8*b +: 8];
            mm[i] = word;
            exp_wr = exp_wr + 1;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
        ren = r; wen = w; addr = a; wmask = m; wdata = d;
        model_step(r, w, a, m, d);
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0;
    endtask

    task automatic idle();
        exp_rvalid = 1'b0; exp_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (rd_cnt !== 32'h0) begin errors++; $display("FAIL reset_rd_cnt got %h want 0", rd_cnt); end
        checks++; if (wr_cnt !== 32'h0) begin errors++; $display("FAIL reset_wr_cnt got %h want 0", wr_cnt); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 32'h8000_0008, 8'hFF, 64'h1122334455667788);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid got %b want 0", rvalid); end
        checks++; if (wr_cnt !== 32'd1) begin errors++; $display("FAIL wr_cnt got %0d want 1", wr_cnt); end
        drive(1'b1, 1'b0, 32'h8000_0008, 8'h00, 64'h0);
        checks++; if (rdata !== 64'h1122334455667788) begin errors++; $display("FAIL rd_data got %h want 1122334455667788", rdata); end
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b want 1", rvalid); end
        checks++; if (rd_cnt !== 32'd1 || wr_cnt !== 32'd1) begin errors++; $display("FAIL rd_cnts got rd=%0d wr=%0d want 1 1", rd_cnt, wr_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", err); end
    endtask

    task automatic test_partial_write();
        drive(1'b0, 1'b1, 32'h8000_0008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        drive(1'b1, 1'b0, 32'h8000_0008, 8'h00, 64'h0);
        checks++; if (rdata !== 64'h11223344_BBBBBBBB) begin errors++; $display("FAIL partial_rdata got %h want 11223344bbbbbbbb", rdata); end
        idle();
        checks++; if (rdata !== 64'h11223344_BBBBBBBB || rvalid !== 1'b0) begin errors++; $display("FAIL hold got %h/%b want 11223344bbbbbbbb/0", rdata, rvalid); end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 1'b1, 32'h8000_0008, 8'hFF, 64'h0);
        checks++; if (rdata !== 64'h11223344_BBBBBBBB || rvalid !== 1'b1) begin errors++; $display("FAIL rbw_old got %h/%b want 11223344bbbbbbbb/1", rdata, rvalid); end
        checks++; if (rd_cnt !== 32'd3 || wr_cnt !== 32'd3) begin errors++; $display("FAIL rbw_cnts got rd=%0d wr=%0d want 3 3", rd_cnt, wr_cnt); end
        drive(1'b1, 1'b0, 32'h8000_0008, 8'h00, 64'h0);
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL rbw_new got %h want 0", rdata); end
    endtask

    task automatic test_out_of_range();
        drive(1'b0, 1'b1, 32'h8000_0000, 8'hFF, 64'h0123456789ABCDEF);
        drive(1'b1, 1'b0, 32'h8000_0000, 8'h00, 64'h0);
        checks++; if (rdata !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL w0_rdata got %h want 0123456789abcdef", rdata); end
        drive(1'b1, 1'b0, 32'h7FFF_FFF8, 8'h00, 64'h0);
        checks++; if (rdata !== 64'h0 || rvalid !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL oor_rd got %h/%b/%b want 0/1/1", rdata, rvalid, err); end
        checks++; if (rd_cnt !== 32'd5 || wr_cnt !== 32'd4) begin errors++; $display("FAIL oor_rd_cnts got rd=%0d wr=%0d want 5 4", rd_cnt, wr_cnt); end
        drive(1'b0, 1'b1, 32'h8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (err !== 1'b1 || wr_cnt !== 32'd4) begin errors++; $display("FAIL oor_wr got err=%b wr=%0d want 1 4", err, wr_cnt); end
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", err); end
        drive(1'b1, 1'b0, 32'h8000_0000, 8'h00, 64'h0);
        checks++; if (rdata !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL oor_nochange got %h want 0123456789abcdef", rdata); end
        drive(1'b0, 1'b1, 32'h8000_7FF8, 8'hFF, 64'h5A5A_1234_5A5A_5678);
        checks++; if (err !== 1'b0 || wr_cnt !== 32'd5) begin errors++; $display("FAIL top_wr got err=%b wr=%0d want 0 5", err, wr_cnt); end
        drive(1'b0, 1'b1, 32'h8000_7FF8, 8'h00, 64'h0);
        drive(1'b1, 1'b0, 32'h8000_7FFF, 8'h00, 64'h0);
        checks++; if (rdata !== 64'h5A5A_1234_5A5A_5678 || rd_cnt !== 32'd7 || wr_cnt !== 32'd6) begin errors++; $display("FAIL top_rd got %h rd=%0d wr=%0d want 5a5a12345a5a5678 7 6", rdata, rd_cnt, wr_cnt); end
    endtask

    task automatic test_reset_mid_read();
        ren = 1'b1; addr = 32'h8000_0000;
        @(posedge clk); #2;
        rst_n = 1'b0;
        wen = 1'b1; wmask = 8'hFF; wdata = 64'h0;
        #1;
        checks++; if (rdata !== 64'h0 || rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_async got %h/%b/%b want 0/0/0", rdata, rvalid, err); end
        checks++; if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnts got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk); ren = 1'b0; wen = 1'b0; rst_n = 1'b1;
        exp_rdata = '0; exp_rvalid = 1'b0; exp_err = 1'b0; exp_rd = '0; exp_wr = '0;
        @(posedge clk); #1;
        checks++; if (rvalid !== 1'b0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin errors++; $display("FAIL rst_release got rvalid=%b rd=%0d wr=%0d want 0 0 0", rvalid, rd_cnt, wr_cnt); end
        drive(1'b1, 1'b0, 32'h8000_0000, 8'h00, 64'h0);
        checks++; if (rdata !== 64'h0123456789ABCDEF || rd_cnt !== 32'd1) begin errors++; $display("FAIL rst_ignore got %h rd=%0d want 0123456789abcdef 1", rdata, rd_cnt); end
    endtask

    task automatic test_counter_wrap();
        force dut.o_wr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.o_wr_cnt;
        drive(1'b0, 1'b1, 32'h8000_0010, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF);
        exp_wr = '0;
        checks++; if (wr_cnt !== 32'h0) begin errors++; $display("FAIL wr_wrap got %h want 0", wr_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int kind;
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 32'(BASE) + 32'(8 * i), 8'hFF, {$urandom, $urandom});
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) a = 32'(BASE) - 32'(8 * $urandom_range(1, 64)) + 32'($urandom_range(0, 7));
            else if (kind == 1) a = 32'(BASE + SPAN) + 32'($urandom_range(0, 255));
            else a = 32'(BASE) + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(0, 7));
            drive(1'($urandom), 1'($urandom), a, 8'($urandom), {$urandom, $urandom});
            checks++;
            if (rdata !== exp_rdata || rvalid !== exp_rvalid || err !== exp_err || rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
                errors++;
                $display("FAIL rand[%0d] addr=%h got %h/%b/%b/%0d/%0d want %h/%b/%b/%0d/%0d", n, a,
                         rdata, rvalid, err, rd_cnt, wr_cnt, exp_rdata, exp_rvalid, exp_err, exp_rd, exp_wr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_same_cycle();
        test_out_of_range();
        test_reset_mid_read();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
